// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: states, ALU ops,
// opcodes and datapath select values.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LINK,
        S_TRAP
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_PASS = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_BEQ  = 4'b1000;
    localparam logic [3:0] ALU_BNE  = 4'b1001;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_LT   = 4'b1100;
    localparam logic [3:0] ALU_GE   = 4'b1101;
    localparam logic [3:0] ALU_LTU  = 4'b1110;
    localparam logic [3:0] ALU_GEU  = 4'b1111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        logic [2:0] sel;
        case (opcode)
            OP_STORE:         sel = IMM_S;
            OP_BRANCH:        sel = IMM_B;
            OP_LUI, OP_AUIPC: sel = IMM_U;
            OP_JAL:           sel = IMM_J;
            default:          sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Maps opcode/funct3/funct7 to the ALU operation for R-type, I-type and branch
// instructions, flagging encodings the core does not implement.
module alu_op_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctrl,
    output logic       illegal
);

    logic funct7_ok;
    assign funct7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

    // alt_sub selects sub for funct3 000; only R-type honours it.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                            input logic alt_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (alt && alt_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_LT;
            3'b011:  op = ALU_LTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (opcode)
            OP_R: begin
                alu_ctrl = arith_op(funct3, funct7[5], 1'b1);
                illegal  = !funct7_ok;
            end
            OP_I: begin
                alu_ctrl = arith_op(funct3, funct7[5], 1'b0);
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
                    illegal = !funct7_ok;
                end
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  alu_ctrl = ALU_BEQ;
                    3'b001:  alu_ctrl = ALU_BNE;
                    3'b100:  alu_ctrl = ALU_LT;
                    3'b101:  alu_ctrl = ALU_GE;
                    3'b110:  alu_ctrl = ALU_LTU;
                    3'b111:  alu_ctrl = ALU_GEU;
                    default: illegal  = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle RISC-V core: sequences one shared ALU
// and one unified memory through fetch/decode/execute/memory/writeback.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        flag,
    output logic [3:0]  ALUctrl,
    output logic [1:0]  ALUsrcA,
    output logic [1:0]  ALUsrcB,
    output logic [2:0]  ImmSrc,
    output logic [1:0]  ResultSrc,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        retire,
    output logic        trap
);

    state_t     state_q, state_d;
    logic [6:0] opcode;
    logic [3:0] dec_alu_ctrl;
    logic       dec_illegal;
    logic       unused_bits;

    assign opcode = instr[6:0];
    // Register fields and immediates belong to the datapath.
    assign unused_bits = ^{instr[24:15], instr[11:7], (W > 0)};

    alu_op_decode u_alu_op_decode (
        .opcode   (opcode),
        .funct3   (instr[14:12]),
        .funct7   (instr[31:25]),
        .alu_ctrl (dec_alu_ctrl),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ALUctrl   = ALU_ADD;
        ALUsrcA   = SRCA_PC;
        ALUsrcB   = SRCB_REGB;
        ImmSrc    = imm_src_of(opcode);
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        retire    = 1'b0;
        trap      = 1'b0;

        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUsrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                PCWrite   = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute OldPC+imm so branch/jal/auipc find it in ALUOut.
                ALUsrcA = SRCA_OLDPC;
                ALUsrcB = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = dec_illegal ? S_TRAP : S_EXECR;
                    OP_I:              state_d = dec_illegal ? S_TRAP : S_EXECI;
                    OP_BRANCH:         state_d = dec_illegal ? S_TRAP : S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUsrcA = SRCA_REGA;
                ALUsrcB = SRCB_IMM;
                state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_MEMDATA;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECR: begin
                ALUsrcA = SRCA_REGA;
                ALUctrl = dec_alu_ctrl;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUsrcA = SRCA_REGA;
                ALUsrcB = SRCB_IMM;
                ALUctrl = dec_alu_ctrl;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                ALUsrcB = SRCB_IMM;
                ALUctrl = ALU_PASS;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUsrcA = SRCA_REGA;
                ALUctrl = dec_alu_ctrl;
                PCWrite = flag;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                PCWrite = 1'b1;
                state_d = S_LINK;
            end
            S_JALR: begin
                ALUsrcA   = SRCA_REGA;
                ALUsrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                PCWrite   = 1'b1;
                state_d   = S_LINK;
            end
            S_LINK: begin
                ALUsrcA   = SRCA_OLDPC;
                ALUsrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset must never let a half-finished instruction commit anything.
        if (rst) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            retire   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected output vectors are
// queued per instruction and compared against the DUT one cycle at a time.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        flag;
    logic [3:0]  ALUctrl;
    logic [1:0]  ALUsrcA;
    logic [1:0]  ALUsrcB;
    logic [2:0]  ImmSrc;
    logic [1:0]  ResultSrc;
    logic        AdrSrc;
    logic        IRWrite;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        retire;
    logic        trap;

    int vectors     = 0;
    int miscompares = 0;

    logic [19:0] exp_q[$];
    string       tag_q[$];
    logic [19:0] observed;

    multicycle_control #(.W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .flag      (flag),
        .ALUctrl   (ALUctrl),
        .ALUsrcA   (ALUsrcA),
        .ALUsrcB   (ALUsrcB),
        .ImmSrc    (ImmSrc),
        .ResultSrc (ResultSrc),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .retire    (retire),
        .trap      (trap)
    );

    always #5 clk = ~clk;

    assign observed = {trap, retire, RegWrite, MemWrite, PCWrite, IRWrite, AdrSrc,
                       ResultSrc, ImmSrc, ALUsrcB, ALUsrcA, ALUctrl};

    function automatic logic [19:0] pack(
        input logic [3:0] alu, input logic [1:0] sa, input logic [1:0] sb,
        input logic [2:0] imm, input logic [1:0] rs, input logic adr,
        input logic ir, input logic pcw, input logic mw, input logic rw,
        input logic ret, input logic tr);
        return {tr, ret, rw, mw, pcw, ir, adr, rs, imm, sb, sa, alu};
    endfunction

    // Expected outputs for each state, written out from the state table.
    function automatic logic [19:0] e_fetch(input logic [2:0] imm);
        return pack(4'b0000, 2'b00, 2'b10, imm, 2'b10, 0, 1, 1, 0, 0, 0, 0);
    endfunction
    function automatic logic [19:0] e_fetch_rst(input logic [2:0] imm);
        return pack(4'b0000, 2'b00, 2'b10, imm, 2'b10, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [19:0] e_decode(input logic [2:0] imm);
        return pack(4'b0000, 2'b01, 2'b01, imm, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [19:0] e_execr(input logic [3:0] alu);
        return pack(alu, 2'b10, 2'b00, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [19:0] e_execi(input logic [3:0] alu);
        return pack(alu, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [19:0] e_aluwb(input logic [2:0] imm);
        return pack(4'b0000, 2'b00, 2'b00, imm, 2'b00, 0, 0, 0, 0, 1, 1, 0);
    endfunction
    function automatic logic [19:0] e_branch(input logic [3:0] alu, input logic f);
        return pack(alu, 2'b10, 2'b00, 3'b010, 2'b00, 0, 0, f, 0, 0, 1, 0);
    endfunction
    function automatic logic [19:0] e_memadr(input logic [2:0] imm);
        return pack(4'b0000, 2'b10, 2'b01, imm, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [19:0] e_trap(input logic [2:0] imm);
        return pack(4'b0000, 2'b00, 2'b00, imm, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    endfunction

    task automatic push(input logic [19:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // Compare one queued vector per clock, sampling just after the falling edge.
    task automatic drain();
        logic [19:0] e;
        string       t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            #1;
            vectors++;
            assert (observed === e) else begin
                miscompares++;
                $error("FAIL %s: observed %05h expected %05h", t, observed, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic run_r(input logic [31:0] ins, input logic [3:0] alu, input string nm);
        instr = ins;
        push(e_fetch(3'b000), {nm, "_fetch"});
        push(e_decode(3'b000), {nm, "_decode"});
        push(e_execr(alu), {nm, "_execr"});
        push(e_aluwb(3'b000), {nm, "_aluwb"});
        drain();
    endtask

    task automatic run_i(input logic [31:0] ins, input logic [3:0] alu, input string nm);
        instr = ins;
        push(e_fetch(3'b000), {nm, "_fetch"});
        push(e_decode(3'b000), {nm, "_decode"});
        push(e_execi(alu), {nm, "_execi"});
        push(e_aluwb(3'b000), {nm, "_aluwb"});
        drain();
    endtask

    task automatic run_branch(input logic [31:0] ins, input logic f, input logic [3:0] alu,
                              input string nm);
        instr = ins;
        flag  = f;
        push(e_fetch(3'b010), {nm, "_fetch"});
        push(e_decode(3'b010), {nm, "_decode"});
        push(e_branch(alu, f), {nm, "_branch"});
        drain();
        flag = 1'b0;
    endtask

    task automatic trap_and_reset(input logic [31:0] ins, input logic [2:0] imm, input int n,
                                  input string nm);
        instr = ins;
        push(e_fetch(imm), {nm, "_fetch"});
        push(e_decode(imm), {nm, "_decode"});
        for (int i = 0; i < n; i++) push(e_trap(imm), {nm, "_trap"});
        drain();
        rst = 1'b1;
        push(e_trap(imm), {nm, "_trap_rst"});
        push(e_fetch_rst(imm), {nm, "_fetch_rst"});
        drain();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        flag  = 1'b0;
        instr = 32'h0000_0013;
        repeat (2) @(posedge clk);
        @(negedge clk);
        push(e_fetch_rst(3'b000), "reset_fetch");
        drain();
        rst = 1'b0;

        // flag high outside BRANCH must not leak into PCWrite
        flag = 1'b1;
        run_r(32'h0020_81B3, 4'b0000, "add");
        flag = 1'b0;
        run_r(32'h4020_81B3, 4'b1010, "sub");
        run_i(32'h4020_D193, 4'b0111, "srai");
        run_r(32'h0020_B1B3, 4'b1110, "sltu");
        run_i(32'h0050_8193, 4'b0000, "addi");

        run_branch(32'h0020_8463, 1'b1, 4'b1000, "beq_taken");
        run_branch(32'h0020_8463, 1'b0, 4'b1000, "beq_nottaken");
        run_branch(32'h0020_E463, 1'b1, 4'b1110, "bltu_taken");

        instr = 32'h0000_A183;
        push(e_fetch(3'b000), "lw_fetch");
        push(e_decode(3'b000), "lw_decode");
        push(e_memadr(3'b000), "lw_memadr");
        push(pack(4'b0000, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 0, 0, 0), "lw_memread");
        push(pack(4'b0000, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0, 0, 0, 1, 1, 0), "lw_memwb");
        drain();

        instr = 32'h0030_A023;
        push(e_fetch(3'b001), "sw_fetch");
        push(e_decode(3'b001), "sw_decode");
        push(e_memadr(3'b001), "sw_memadr");
        push(pack(4'b0000, 2'b00, 2'b00, 3'b001, 2'b00, 1, 0, 0, 1, 0, 1, 0), "sw_memwrite");
        drain();

        instr = 32'h0000_80E7;
        push(e_fetch(3'b000), "jalr_fetch");
        push(e_decode(3'b000), "jalr_decode");
        push(pack(4'b0000, 2'b10, 2'b01, 3'b000, 2'b10, 0, 0, 1, 0, 0, 0, 0), "jalr_jalr");
        push(pack(4'b0000, 2'b01, 2'b10, 3'b000, 2'b10, 0, 0, 0, 0, 1, 1, 0), "jalr_link");
        drain();

        instr = 32'h0080_00EF;
        push(e_fetch(3'b100), "jal_fetch");
        push(e_decode(3'b100), "jal_decode");
        push(pack(4'b0000, 2'b00, 2'b00, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 0), "jal_jal");
        push(pack(4'b0000, 2'b01, 2'b10, 3'b100, 2'b10, 0, 0, 0, 0, 1, 1, 0), "jal_link");
        drain();

        instr = 32'h1234_51B7;
        push(e_fetch(3'b011), "lui_fetch");
        push(e_decode(3'b011), "lui_decode");
        push(pack(4'b0001, 2'b00, 2'b01, 3'b011, 2'b00, 0, 0, 0, 0, 0, 0, 0), "lui_lui");
        push(e_aluwb(3'b011), "lui_aluwb");
        drain();

        instr = 32'h0000_1197;
        push(e_fetch(3'b011), "auipc_fetch");
        push(e_decode(3'b011), "auipc_decode");
        push(e_aluwb(3'b011), "auipc_aluwb");
        drain();

        trap_and_reset(32'h0000_007F, 3'b000, 20, "bad_opcode");
        trap_and_reset(32'h0020_A463, 3'b010, 2, "bad_branch_f3");
        trap_and_reset(32'h8020_81B3, 3'b000, 2, "bad_r_f7");
        trap_and_reset(32'h0220_9193, 3'b000, 2, "bad_slli_f7");

        // Reset while a load sits in MEMREAD: no writeback may follow.
        instr = 32'h0000_A183;
        push(e_fetch(3'b000), "lwrst_fetch");
        push(e_decode(3'b000), "lwrst_decode");
        push(e_memadr(3'b000), "lwrst_memadr");
        drain();
        rst = 1'b1;
        push(pack(4'b0000, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0, 0, 0, 0), "lwrst_memread");
        push(e_fetch_rst(3'b000), "lwrst_fetch_after");
        drain();
        rst = 1'b0;

        run_r(32'h0020_81B3, 4'b0000, "add_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control FSM for the multi-cycle RISC-V core; drives the ALU's 4-bit ALUctrl and consumes the ALU's `flag` output to resolve branches.
- Sequences fetch, decode, execute, memory and writeback through a single shared ALU and a single unified memory.
- Generates all datapath select and write-enable strobes as Moore outputs of the state register plus the instruction register.

Parameters:
W, 32, datapath width (informational; instr is fixed at 32 bits)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr  in  32  instruction register contents, valid from DECODE onward
flag  in  1  ALU flag (branch condition result)
ALUctrl  out  4  ALU operation
ALUsrcA  out  2  00 PC, 01 OldPC, 10 regA
ALUsrcB  out  2  00 regB, 01 imm, 10 const 4
ImmSrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J
ResultSrc  out  2  00 ALUOut reg, 01 mem data reg, 10 ALU result direct
AdrSrc  out  1  0 PC, 1 Result
IRWrite  out  1  load IR and OldPC
PCWrite  out  1  PC <= Result
MemWrite  out  1  memory write strobe
RegWrite  out  1  regfile write strobe
retire  out  1  one-cycle pulse on last cycle of each instruction
trap  out  1  illegal instruction, sticky until reset

Behaviour:
- ALUctrl encoding:
  - 0000 add, 0001 pass N2, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra
  - 1000 beq, 1001 bne, 1010 sub, 1100 blt/slt, 1101 bge, 1110 bltu/sltu, 1111 bgeu
- Defaults in every state: all strobes 0, ALUctrl 0000, selects 00.
- ImmSrc is decoded from the opcode in all states.
- States and the outputs each one asserts:
  - FETCH: AdrSrc 0, IRWrite, srcA PC, srcB 4, add, ResultSrc 10, PCWrite. Next: DECODE.
  - DECODE: srcA OldPC, srcB imm, add (branch/jal/auipc target latched into ALUOut). Next by opcode:
    - 0000011, 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> ALUWB
    - any other opcode -> TRAP
  - MEMADR: srcA regA, srcB imm, add. Next: MEMREAD if opcode 0000011, else MEMWRITE.
  - MEMREAD: AdrSrc 1, ResultSrc 00. Next: MEMWB.
  - MEMWB: ResultSrc 01, RegWrite, retire. Next: FETCH.
  - MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite, retire. Next: FETCH.
  - EXECR: srcA regA, srcB regB, ALUctrl from funct. Next: ALUWB.
  - EXECI: srcA regA, srcB imm, ALUctrl from funct. Next: ALUWB.
  - LUI: srcB imm, ALUctrl 0001. Next: ALUWB.
  - ALUWB: ResultSrc 00, RegWrite, retire. Next: FETCH.
  - BRANCH: srcA regA, srcB regB, ALUctrl from funct3, ResultSrc 00, PCWrite = flag, retire. Next: FETCH.
  - JAL: ResultSrc 00, PCWrite. Next: LINK.
  - JALR: srcA regA, srcB imm, add, ResultSrc 10, PCWrite. Next: LINK. Clearing target bit 0 is the datapath's job.
  - LINK: srcA OldPC, srcB 4, add, ResultSrc 10, RegWrite, retire. Next: FETCH.
  - TRAP: all strobes 0, trap 1. Stays in TRAP until rst.
- Branch funct3 -> ALUctrl: 000->1000, 001->1001, 100->1100, 101->1101, 110->1110, 111->1111; 010 and 011 -> TRAP. The decision to trap is made in DECODE.
- R-type funct3 -> ALUctrl:
  - 000 -> add (funct7[5]=0) or 1010 sub (funct7[5]=1)
  - 001 sll, 010 1100, 011 1110, 100 xor
  - 101 -> srl (funct7[5]=0) or sra (funct7[5]=1)
  - 110 or, 111 and
  - funct7 other than 0000000/0100000 -> TRAP
- I-type funct3 -> ALUctrl: same map, but funct3 000 is always add; funct7[5] is examined only for 101. slli/srli/srai with funct7 not 0000000/0100000 -> TRAP.
- Latency per instruction class:
  - load: 5 cycles
  - store, R/I-type, lui: 4 cycles
  - auipc, branch: 3 cycles
  - jal, jalr: 4 cycles
- Reset:
  - rst sampled high at a clock edge -> state FETCH, trap cleared.
  - While rst is high, all write strobes and retire are forced to 0 combinationally, regardless of state.
  - Reset mid-instruction abandons the instruction with no partial write.
- flag is sampled only in BRANCH; ignored in all other states.

Decomposition:
- Package ctrl_pkg holds:
  - state enum
  - ALUctrl localparams
  - opcode constants
  - ALUsrcA/ALUsrcB/ResultSrc/ImmSrc encodings
- Sub-module alu_op_decode: combinational map of opcode/funct3/funct7 to ALUctrl plus an illegal bit, shared by EXECR, EXECI and BRANCH.

Test Plan:
- add x3,x1,x2 (0x002081B3) after reset -> states FETCH,DECODE,EXECR,ALUWB; ALUctrl 0000 in EXECR; RegWrite and retire high only in ALUWB.
- sub (0x402081B3) -> ALUctrl 1010 in EXECR; srai (0x4020D193) -> 0111; sltu (0x0020B1B3) -> 1110.
- beq 0x00208463 with flag=1 -> BRANCH ALUctrl 1000, PCWrite 1; repeat with flag=0 -> PCWrite 0; both take 3 cycles to next FETCH.
- lw 0x0000A183 -> 5 cycles, AdrSrc 1 in MEMREAD, RegWrite with ResultSrc 01 in MEMWB; sw 0x0030A023 -> MemWrite single cycle in MEMWRITE.
- jalr 0x000080E7 -> JALR PCWrite with ResultSrc 10, then LINK with RegWrite and srcA 01/srcB 10.
- Opcode 0x0000007F -> TRAP, trap sticky for 20 cycles, no strobes; assert rst mid-LOAD at MEMREAD -> next state FETCH, no RegWrite.
